// File: rtl/daw_pkg.sv
// daw_pkg: shared types and constants for the audio capture path
package daw_pkg;
  typedef enum logic [1:0] {PK_IDLE, PK_PRIME, PK_RUN, PK_FLUSH} packer_state_t;
  localparam int SD_BLOCK_BYTES = 512;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead FIFO taking two entries per write and giving one per read
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push2,
  input  logic                   pop,
  input  logic [2*WIDTH-1:0]     din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full2,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic full, do_pop, do_push;
  assign level = wp - rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  // a same-cycle read frees the slot the second write byte needs
  assign full2 = full | (level == (AW+1)'(DEPTH-1) & ~do_pop);
  assign do_push = push2 & ~full2 & ~clr;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 2'd2;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) begin
      mem[wp[AW-1:0]] <= din[WIDTH-1:0];
      mem[wp[AW-1:0] + 1'b1] <= din[2*WIDTH-1:WIDTH];
    end
endmodule

// File: rtl/sample_byte_packer.sv
// sample_byte_packer: packs 16-bit samples into bytes for the SD recorder, padding each take to a full sector
module sample_byte_packer
  import daw_pkg::*;
#(
  parameter int FIFO_DEPTH  = 1024,
  parameter int PRIME_BYTES = 64,
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        record_en,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  input  logic        byte_req,
  output logic [7:0]  byte_out,
  output logic        record_req,
  output logic        overflow,
  output logic [15:0] underrun_cnt
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BLOCK_BYTES);
  packer_state_t state;
  logic byte_req_d, clr, push, pop, full2, empty, last;
  logic [BW-1:0] blk_cnt;
  logic [LW-1:0] level;
  logic [7:0] head;
  assign pop = byte_req & ~byte_req_d & record_req;
  assign push = sample_valid & ((state == PK_PRIME & record_en) | state == PK_RUN);
  assign clr = (state == PK_IDLE & record_en) | (state == PK_PRIME & ~record_en);
  assign byte_out = empty ? 8'h00 : head;
  // final byte of a sector with nothing left queued behind it
  assign last = state == PK_FLUSH & pop & blk_cnt == BW'(BLOCK_BYTES-1) & level <= LW'(1);
  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst(rst), .clr(clr), .push2(push), .pop(pop), .din(sample_in),
    .dout(head), .level(level), .full2(full2), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= PK_IDLE;
      byte_req_d <= 1'b0;
      blk_cnt <= '0;
      record_req <= 1'b0;
      overflow <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      byte_req_d <= byte_req;
      if (push & full2) overflow <= 1'b1;
      if (pop) blk_cnt <= blk_cnt + 1'b1;
      if (pop & empty & state == PK_RUN & ~&underrun_cnt) underrun_cnt <= underrun_cnt + 1'b1;
      case (state)
        PK_IDLE:
          if (record_en) begin
            state <= PK_PRIME;
            blk_cnt <= '0;
            overflow <= 1'b0;
            underrun_cnt <= '0;
          end
        PK_PRIME:
          if (!record_en) state <= PK_IDLE;
          else if (level >= LW'(PRIME_BYTES)) begin
            state <= PK_RUN;
            record_req <= 1'b1;
          end
        PK_RUN:
          if (!record_en) state <= PK_FLUSH;
        default:
          if (last) begin
            state <= PK_IDLE;
            record_req <= 1'b0;
            blk_cnt <= '0;
          end
      endcase
    end
endmodule
